// File: rtl/apb_reg_slave_pkg.sv
// Shared types and address-decode helper for the APB register slave.
package apb_reg_slave_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } apb_slv_state_e;

  localparam int APB_WORD_LSB = 2;

  // Word-aligned and inside the register window.
  function automatic logic is_legal_addr(input logic [63:0] paddr, input int num_regs);
    logic [63:0] limit;
    limit = 64'(num_regs) << 2;
    return (paddr[1:0] == 2'b00) && (paddr < limit);
  endfunction

endpackage

// File: rtl/apb_reg_slave_if.sv
// APB bus bundle with initiator (master) and completer (slave) views.
interface apb_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    psel;
  logic                    penable;
  logic [ADDR_WIDTH-1:0]   paddr;
  logic                    pwrite;
  logic [DATA_WIDTH-1:0]   pwdata;
  logic [DATA_WIDTH/8-1:0] pstrb;
  logic                    pready;
  logic [DATA_WIDTH-1:0]   prdata;
  logic                    pslverr;

  modport master (
    output psel, penable, paddr, pwrite, pwdata, pstrb,
    input  pready, prdata, pslverr
  );

  modport slave (
    input  psel, penable, paddr, pwrite, pwdata, pstrb,
    output pready, prdata, pslverr
  );
endinterface

// File: rtl/apb_reg_slave_bank.sv
// Register array: byte-strobed write port, combinational read port, flattened export.
module apb_reg_slave_bank #(
  parameter int NUM_REGS   = 8,
  parameter int DATA_WIDTH = 32
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           we,
  input  logic [$clog2(NUM_REGS)-1:0]    widx,
  input  logic [DATA_WIDTH-1:0]          wdata,
  input  logic [DATA_WIDTH/8-1:0]        wstrb,
  input  logic [$clog2(NUM_REGS)-1:0]    ridx,
  output logic [DATA_WIDTH-1:0]          rdata,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int STRB_W = DATA_WIDTH / 8;

  logic [DATA_WIDTH-1:0] mem_r [NUM_REGS];

  // Register storage with per-byte write enables.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        mem_r[i] <= {DATA_WIDTH{1'b0}};
      end
    end else if (we) begin
      for (int b = 0; b < STRB_W; b++) begin
        if (wstrb[b]) begin
          mem_r[widx][8*b +: 8] <= wdata[8*b +: 8];
        end
      end
    end
  end

  assign rdata = mem_r[ridx];

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_o[g*DATA_WIDTH +: DATA_WIDTH] = mem_r[g];
  end
endmodule

// File: rtl/apb_reg_slave.sv
// APB completer with a bank of R/W registers and fixed wait states.
// Optional macro APB_REG_SLAVE_ERR_EN: illegal accesses answer with pslverr=1.
module apb_reg_slave
  import apb_reg_slave_pkg::*;
#(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_REGS    = 8,
  parameter int WAIT_CYCLES = 0
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  apb_if.slave                           apb,
  output logic [NUM_REGS*DATA_WIDTH-1:0] regs_o
);
  localparam int          IDX_W    = $clog2(NUM_REGS);
  localparam int          STRB_W   = DATA_WIDTH / 8;
  localparam logic [3:0]  WAIT_CNT = 4'(WAIT_CYCLES);
`ifdef APB_REG_SLAVE_ERR_EN
  localparam logic        ERR_EN   = 1'b1;
`else
  localparam logic        ERR_EN   = 1'b0;
`endif

  apb_slv_state_e         state_r;
  logic [3:0]             cnt_r;
  logic [IDX_W-1:0]       idx_r;
  logic                   wr_r;
  logic                   legal_r;
  logic [DATA_WIDTH-1:0]  wdata_r;
  logic [STRB_W-1:0]      wstrb_r;
  logic                   pready_r;
  logic [DATA_WIDTH-1:0]  prdata_r;
  logic                   pslverr_r;

  logic [ADDR_WIDTH-1:0]  paddr_s;
  logic                   setup_s;
  logic [IDX_W-1:0]       dec_idx_s;
  logic                   dec_legal_s;
  logic [IDX_W-1:0]       rsp_idx_s;
  logic                   rsp_legal_s;
  logic                   rsp_rd_s;
  logic [DATA_WIDTH-1:0]  rsp_data_s;
  logic                   rsp_err_s;
  logic [DATA_WIDTH-1:0]  bank_rdata_s;
  logic                   commit_s;

  assign paddr_s     = apb.paddr;
  assign setup_s     = apb.psel && !apb.penable;
  assign dec_idx_s   = paddr_s[IDX_W+APB_WORD_LSB-1:APB_WORD_LSB];
  assign dec_legal_s = is_legal_addr(64'(paddr_s), NUM_REGS);
  assign commit_s    = (state_r == RESP) && apb.psel && apb.penable && pready_r && wr_r && legal_r;

  // Response source: live decode when leaving IDLE, latched decode otherwise.
  always_comb begin
    rsp_idx_s   = idx_r;
    rsp_legal_s = legal_r;
    rsp_rd_s    = !wr_r;
    if (state_r == IDLE) begin
      rsp_idx_s   = dec_idx_s;
      rsp_legal_s = dec_legal_s;
      rsp_rd_s    = !apb.pwrite;
    end else begin
      rsp_idx_s   = idx_r;
      rsp_legal_s = legal_r;
      rsp_rd_s    = !wr_r;
    end
    rsp_data_s = (rsp_rd_s && rsp_legal_s) ? bank_rdata_s : {DATA_WIDTH{1'b0}};
    rsp_err_s  = ERR_EN && !rsp_legal_s;
  end

  // Transfer FSM, wait counter and registered response outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= IDLE;
      cnt_r     <= 4'd0;
      idx_r     <= {IDX_W{1'b0}};
      wr_r      <= 1'b0;
      legal_r   <= 1'b0;
      wdata_r   <= {DATA_WIDTH{1'b0}};
      wstrb_r   <= {STRB_W{1'b0}};
      pready_r  <= 1'b0;
      prdata_r  <= {DATA_WIDTH{1'b0}};
      pslverr_r <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (setup_s) begin
            idx_r   <= dec_idx_s;
            wr_r    <= apb.pwrite;
            legal_r <= dec_legal_s;
            wdata_r <= apb.pwdata;
            wstrb_r <= apb.pstrb;
            cnt_r   <= WAIT_CNT;
            if (WAIT_CNT == 4'd0) begin
              state_r   <= RESP;
              pready_r  <= 1'b1;
              prdata_r  <= rsp_data_s;
              pslverr_r <= rsp_err_s;
            end else begin
              state_r <= WAIT;
            end
          end
        end
        WAIT: begin
          if (!apb.psel) begin
            state_r <= IDLE;
            cnt_r   <= 4'd0;
          end else begin
            cnt_r <= cnt_r - 4'd1;
            if (cnt_r == 4'd1) begin
              state_r   <= RESP;
              pready_r  <= 1'b1;
              prdata_r  <= rsp_data_s;
              pslverr_r <= rsp_err_s;
            end
          end
        end
        RESP: begin
          // Completion or abort both return to IDLE; the write itself commits in the bank.
          if (!apb.psel || apb.penable) begin
            state_r   <= IDLE;
            cnt_r     <= 4'd0;
            pready_r  <= 1'b0;
            prdata_r  <= {DATA_WIDTH{1'b0}};
            pslverr_r <= 1'b0;
          end
        end
        default: begin
          state_r   <= IDLE;
          cnt_r     <= 4'd0;
          pready_r  <= 1'b0;
          prdata_r  <= {DATA_WIDTH{1'b0}};
          pslverr_r <= 1'b0;
        end
      endcase
    end
  end

  assign apb.pready  = pready_r;
  assign apb.prdata  = prdata_r;
  assign apb.pslverr = pslverr_r;

  apb_reg_slave_bank #(
    .NUM_REGS   (NUM_REGS),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_bank (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .we     (commit_s),
    .widx   (idx_r),
    .wdata  (wdata_r),
    .wstrb  (wstrb_r),
    .ridx   (rsp_idx_s),
    .rdata  (bank_rdata_s),
    .regs_o (regs_o)
  );
endmodule
